// File: rtl/note_spawn_scheduler.sv
// Paces arrow spawns from the difficulty code and offers one lane mask per interval over valid/ready.
// Optional DOUBLE_ARROW_EN: some loads add the opposite lane to form a two-lane chord.
module note_spawn_scheduler #(
    parameter int         SPAWN_BASE = 16,
    parameter int         CNT_W      = 8,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_en,
    input  logic        frame_tick,
    input  logic [1:0]  difficulty_converted,
    input  logic        spawn_ready,
    output logic        spawn_valid,
    output logic [3:0]  spawn_lanes,
    output logic [15:0] spawn_count,
    output logic [7:0]  skipped_count
);

    typedef enum logic [1:0] {IDLE, COUNT, OFFER} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] interval;
    logic [7:0]       lfsr;
    logic [3:0]       new_mask;
    logic             running, transfer, expire, load_mask, skip, relatch;

    // Code 0 stands for the slowest pace, four difficulty units.
    function automatic logic [CNT_W-1:0] interval_of(input logic [1:0] code);
        logic [CNT_W-1:0] units;
        units = (code == 2'd0) ? CNT_W'(4) : CNT_W'(code);
        return units * CNT_W'(SPAWN_BASE);
    endfunction

    assign spawn_valid = (state == OFFER);
    assign running     = game_en && (state != IDLE);
    assign transfer    = spawn_valid && spawn_ready;
    assign expire      = running && frame_tick && (frame_cnt == interval - 1'b1);
    assign relatch     = ((state == IDLE) && game_en) || expire;

    always_comb begin
        new_mask = 4'b0001 << lfsr[1:0];
`ifdef DOUBLE_ARROW_EN
        if (lfsr[7:5] == 3'b111)
            new_mask = new_mask | (4'b0001 << (lfsr[1:0] + 2'd2));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_mask = 1'b0;
        skip      = 1'b0;
        case (state)
            IDLE: begin
                if (game_en) state_nxt = COUNT;
            end
            COUNT: begin
                if (!game_en) begin
                    state_nxt = IDLE;
                end else if (expire) begin
                    state_nxt = OFFER;
                    load_mask = 1'b1;
                end
            end
            OFFER: begin
                // An offer still pending at expiry is kept; the lost interval is only counted.
                if (!game_en) begin
                    state_nxt = IDLE;
                end else if (expire) begin
                    if (spawn_ready) load_mask = 1'b1;
                    else             skip      = 1'b1;
                end else if (spawn_ready) begin
                    state_nxt = COUNT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt     <= '0;
            interval      <= interval_of(2'd2);
            lfsr          <= LFSR_SEED;
            spawn_lanes   <= 4'b0000;
            spawn_count   <= 16'd0;
            skipped_count <= 8'd0;
        end else begin
            if (game_en)
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

            if (!running || expire) frame_cnt <= '0;
            else if (frame_tick)    frame_cnt <= frame_cnt + 1'b1;

            if (relatch)   interval    <= interval_of(difficulty_converted);
            if (load_mask) spawn_lanes <= new_mask;

            // A transfer in the cycle game_en falls still counts.
            if (transfer) spawn_count <= spawn_count + 16'd1;
            if (skip && (skipped_count != 8'hFF)) skipped_count <= skipped_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_note_spawn_scheduler.sv
// Randomized and directed bench for note_spawn_scheduler against an event-level model of the pacing rules.
module tb_note_spawn_scheduler;
    localparam int SB = 4;

    logic        clk = 1'b0;
    logic        rst, game_en, frame_tick, spawn_ready;
    logic [1:0]  difficulty_converted;
    logic        spawn_valid;
    logic [3:0]  spawn_lanes;
    logic [15:0] spawn_count;
    logic [7:0]  skipped_count;

    int errors = 0;
    int checks = 0;

    note_spawn_scheduler #(.SPAWN_BASE(SB), .CNT_W(8), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst(rst), .game_en(game_en), .frame_tick(frame_tick),
        .difficulty_converted(difficulty_converted), .spawn_ready(spawn_ready),
        .spawn_valid(spawn_valid), .spawn_lanes(spawn_lanes),
        .spawn_count(spawn_count), .skipped_count(skipped_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_active, m_valid, chk_en;
    logic [3:0]  m_mask;
    int          m_ticks, m_int, m_spawns, m_skips;
    logic [7:0]  m_lfsr;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        // polynomial x^8+x^6+x^5+x^4+1, shifted left with feedback into bit 0
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic int interval_ticks(input logic [1:0] code);
        return ((code == 2'd0) ? 4 : int'(code)) * SB;
    endfunction

    function automatic logic [3:0] lanes_of(input logic [7:0] v);
        int l;
        logic [3:0] m;
        l = int'(v[1:0]);
        m = 4'd1 << l;
`ifdef DOUBLE_ARROW_EN
        if (v[7:5] == 3'b111) m = m | (4'd1 << ((l + 2) % 4));
`endif
        return m;
    endfunction

    always @(posedge clk) begin
        bit xfer;
        if (rst) begin
            m_active = 0; m_valid = 0; m_mask = 4'b0; m_ticks = 0;
            m_int = 2 * SB; m_spawns = 0; m_skips = 0; m_lfsr = 8'hA5;
            chk_en = 1;
        end else if (chk_en) begin
            xfer = m_valid && spawn_ready;
            if (xfer) m_spawns = (m_spawns + 1) % 65536;
            m_valid = m_valid && !xfer;
            if (!game_en) begin
                m_active = 0; m_valid = 0; m_ticks = 0;
            end else if (!m_active) begin
                m_active = 1; m_ticks = 0; m_int = interval_ticks(difficulty_converted);
            end else if (frame_tick) begin
                if (m_ticks + 1 == m_int) begin
                    m_ticks = 0;
                    m_int = interval_ticks(difficulty_converted);
                    if (m_valid) begin
                        if (m_skips < 255) m_skips++;
                    end else begin
                        m_valid = 1;
                        m_mask  = lanes_of(m_lfsr);
                    end
                end else begin
                    m_ticks++;
                end
            end
            if (game_en) m_lfsr = lfsr_step(m_lfsr);
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    int accepted = 0, twohot = 0, badmask = 0, rnd_phase = 0;
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            cmp("spawn_valid", {31'b0, spawn_valid}, {31'b0, m_valid});
            if (m_valid) cmp("spawn_lanes", {28'b0, spawn_lanes}, {28'b0, m_mask});
            cmp("spawn_count", {16'b0, spawn_count}, m_spawns);
            cmp("skipped_count", {24'b0, skipped_count}, m_skips);
            if (rnd_phase && spawn_valid && spawn_ready) begin
                accepted++;
                if ($countones(spawn_lanes) == 2) begin
                    twohot++;
                    if (spawn_lanes != 4'b0101 && spawn_lanes != 4'b1010) badmask++;
                end else if ($countones(spawn_lanes) != 1) begin
                    badmask++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(gap - 1);
        end
    endtask

    initial begin
        int base;
        rst = 1; game_en = 0; frame_tick = 0; spawn_ready = 1; difficulty_converted = 2'd1;
        cmp("model_lfsr_1", lfsr_step(8'hA5), 8'h4A);
        cmp("model_lfsr_2", lfsr_step(8'h4A), 8'h95);
        cyc(3);
        rst = 0;
        cyc(1);
        cmp("reset_valid", {31'b0, spawn_valid}, 0);
        cmp("reset_count", {16'b0, spawn_count}, 0);
        cmp("reset_skipped", {24'b0, skipped_count}, 0);

        // code 1: one spawn per 4 ticks
        game_en = 1; cyc(1);
        tick(20, 10);
        cmp("code1_20ticks", {16'b0, spawn_count}, 5);

        // code 3 then mid-interval switch to code 1
        game_en = 0; cyc(2);
        difficulty_converted = 2'd3; game_en = 1; cyc(1);
        base = int'(spawn_count);
        tick(12, 10);
        cmp("code3_first", {16'b0, spawn_count}, base + 1);
        tick(6, 10);
        difficulty_converted = 2'd1;
        tick(6, 10);
        cmp("code3_kept", {16'b0, spawn_count}, base + 2);
        tick(4, 10);
        cmp("code1_after", {16'b0, spawn_count}, base + 3);

        // back-pressure
        game_en = 0; spawn_ready = 0; difficulty_converted = 2'd1;
        rst = 1; cyc(1); rst = 0;
        game_en = 1; cyc(1);
        tick(9, 10);
        cmp("bp_skipped", {24'b0, skipped_count}, 1);
        cmp("bp_valid", {31'b0, spawn_valid}, 1);
        cmp("bp_count", {16'b0, spawn_count}, 0);
        spawn_ready = 1; cyc(2);
        cmp("bp_released", {16'b0, spawn_count}, 1);

        // saturation
        spawn_ready = 0;
        tick(1200, 2);
        cmp("skip_saturate", {24'b0, skipped_count}, 255);
        cmp("sat_valid", {31'b0, spawn_valid}, 1);

        // game_en drop with a pending offer
        base = int'(spawn_count);
        game_en = 0; cyc(1);
        cmp("drop_valid", {31'b0, spawn_valid}, 0);
        cmp("drop_count", {16'b0, spawn_count}, base);
        spawn_ready = 1; game_en = 1; cyc(1);
        tick(3, 4);
        cmp("restart_early", {16'b0, spawn_count}, base);
        tick(1, 4);
        cmp("restart_full", {16'b0, spawn_count}, base + 1);

        // randomized phase
        rnd_phase = 1;
        for (int i = 0; i < 6000; i++) begin
            rst         = ($urandom_range(2999) == 0);
            game_en     = ($urandom_range(299) != 0);
            frame_tick  = $urandom_range(1);
            spawn_ready = ($urandom_range(3) != 0);
            if ($urandom_range(49) == 0) difficulty_converted = 2'($urandom_range(3));
            cyc(1);
        end
        rst = 0; frame_tick = 0; rnd_phase = 0;
        cyc(2);
        checks++;
        if (accepted < 200) begin
            errors++;
            $display("FAIL rnd_spawns: got %0d expected at least 200", accepted);
        end
        cmp("rnd_bad_masks", badmask, 0);
`ifdef DOUBLE_ARROW_EN
        checks++;
        if (twohot == 0) begin
            errors++;
            $display("FAIL rnd_chords: got %0d expected nonzero", twohot);
        end
`else
        cmp("rnd_chords", twohot, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
